data_memory_mmio: RTL and testbench
===================================

Name: data_memory_mmio

Overview:
MEM-stage data memory with memory-mapped peripherals. It sits between EX/MEM and MEM/WB.
- Takes the ALU result as an address, plus read/write strobes.
- Returns a 32-bit read word that MEM/WB captures on the next clk edge.
- Contains a word RAM, a reloadable interrupt timer, an LED register, a 7-segment digit register and a free-running systick counter.

Parameters:
RAM_WORDS, 512, data RAM depth in 32-bit words; power of two; byte address range 0 .. 4*RAM_WORDS-4.
ADDR_W, 9, log2(RAM_WORDS); RAM word index = i_addr[ADDR_W+1:2].

Ports:
clk  in  1  clock, all state updates on rising edge.
reset  in  1  asynchronous, active-high.
i_mem_read  in  1  read strobe.
i_mem_write  in  1  write strobe.
i_addr  in  32  byte address; bits [1:0] ignored (word access only).
i_write_data  in  32  store data.
o_read_data  out  32  combinational read word, consumed by MEM/WB.
o_irq  out  1  timer interrupt request to the control unit.
o_leds  out  8  LED register.
o_digits  out  12  7-segment register: [11:8] anode select, [7:0] segments.
o_systick  out  32  systick count.

Behaviour:
Reset
- Asynchronous, active-high. While reset is high, all peripheral registers clear to 0: TH, TL, TCON, LEDs, digits, systick.
- Consequently o_irq = 0, o_leds = 0, o_digits = 0, o_systick = 0.
- RAM contents are not reset; they are undefined until written.
- o_read_data is combinational, so it equals 0 during reset unless a RAM read is active.

Address map (i_addr[1:0] ignored)
- 0x00000000 .. 4*RAM_WORDS-4: RAM.
- 0x40000000: TH, timer reload value, R/W.
- 0x40000004: TL, timer count, R/W.
- 0x40000008: TCON, R/W; bits [2:0] stored, [31:3] read 0.
  - bit0 = enable.
  - bit1 = irq enable.
  - bit2 = irq status.
- 0x4000000C: LEDs, R/W, low 8 bits.
- 0x40000010: digits, R/W, low 12 bits.
- 0x40000014: systick, read-only; writes ignored.
- Any other address: reads return 0, writes ignored, no error signalled.

Read path
- Zero latency: o_read_data is combinational from i_addr and current state.
- i_mem_read = 0 gives o_read_data = 0.
- A read and a write to the same address in the same cycle return the old (pre-edge) value.
- Unused upper bits of peripheral registers read 0.

Write path
- Synchronous on rising clk when i_mem_write = 1.
- i_mem_read and i_mem_write both high is legal: read returns old data, write commits at the edge.

Timer (every cycle, TCON[0] = 1)
- If TL == 32'hFFFFFFFF: TL <= TH.
  - If TCON[1] = 1, also TCON[2] <= 1.
- Otherwise TL <= TL + 1, wrapping modulo 2^32.
- TCON[0] = 0: TL holds its value.
- o_irq = TCON[1] & TCON[2], registered-derived with no combinational path from inputs.
- Status stays set until software writes TCON with bit2 = 0.

Systick
- Increments every cycle after reset deasserts; wraps from 0xFFFFFFFF to 0.

Collisions
- A CPU write to TL in the same cycle as a timer update wins; the timer update is dropped for that cycle.
- A CPU write to TCON in the same cycle as an overflow wins for all three bits, so a status set in that cycle is lost. Software clears status only when the timer is disabled or after reading TL.
- A CPU write to TH in an overflow cycle: the reload uses the old TH.

Reset mid-operation
- All counters return to 0 immediately (async).
- The first increment happens on the first rising edge after reset falls.

Decomposition:
Shared package (cpu_pkg)
- Peripheral base address 0x40000000 and the six register offsets.
- TCON bit indices (TCON_EN = 0, TCON_IE = 1, TCON_IS = 2).
- RAM_WORDS default.

Sub-module: timer_unit
- Holds TH, TL, TCON and the overflow logic.
- Inputs: write strobes and data. Outputs: register values and irq.
- The RAM array, LED/digit registers, systick and the read mux stay in data_memory_mmio.

Test Plan:
- RAM: write 0xDEADBEEF to 0x00000010, then read 0x00000010 next cycle → 0xDEADBEEF. Read 0x00000013 → same word. Read with i_mem_read = 0 → 0.
- Timer reload/irq:
  - Stimulus: TH = 0xFFFFFFFD, TL = 0xFFFFFFFE, TCON = 3.
  - TL = 0xFFFFFFFF after 1 cycle; 0xFFFFFFFD after 2 cycles.
  - TCON reads 7 and o_irq = 1 after cycle 2.
  - Write TCON = 3 → o_irq = 0 next cycle.
- Collision: in the overflow cycle, write TL = 0x00000005 → TL = 5 next cycle, not TH. Write TCON = 1 in an overflow cycle → TCON = 1, o_irq = 0.
- Peripherals: write LEDs 0x1A5 → o_leds = 0xA5 and reads 0x000000A5. Write digits 0xFFFF → o_digits = 0xFFF. Write 0x40000014 → systick unaffected.
- Unmapped: write 0x12345678 to 0x40000020, then read → 0. Read 0x80000000 → 0.
- Reset: assert reset mid-count with TL = 0x100, TCON = 7 → TL, TCON, o_irq, o_systick = 0 immediately. o_systick = 1 one edge after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the MEM-stage data memory: address map, TCON bit
// positions and the address decoder used by the bus logic.
package cpu_pkg;

  localparam int RAM_WORDS_DEFAULT = 512;

  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;
  localparam logic [31:0] OFF_TH      = 32'h0000_0000;
  localparam logic [31:0] OFF_TL      = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
  localparam logic [31:0] OFF_LEDS    = 32'h0000_000C;
  localparam logic [31:0] OFF_DIGITS  = 32'h0000_0010;
  localparam logic [31:0] OFF_SYSTICK = 32'h0000_0014;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LEDS,
    SEL_DIGITS,
    SEL_SYSTICK
  } sel_e;

  // Word accesses only: the two low address bits never take part in decode.
  function automatic sel_e decode(input logic [31:0] addr, input logic [31:0] ram_bytes);
    logic [31:0] word_addr;
    word_addr = {addr[31:2], 2'b00};
    if (word_addr < ram_bytes) begin
      return SEL_RAM;
    end
    case (word_addr)
      PERIPH_BASE + OFF_TH:      return SEL_TH;
      PERIPH_BASE + OFF_TL:      return SEL_TL;
      PERIPH_BASE + OFF_TCON:    return SEL_TCON;
      PERIPH_BASE + OFF_LEDS:    return SEL_LEDS;
      PERIPH_BASE + OFF_DIGITS:  return SEL_DIGITS;
      PERIPH_BASE + OFF_SYSTICK: return SEL_SYSTICK;
      default:                   return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/timer_unit.sv
// Reloadable interrupt timer: TH reload value, TL up-counter and TCON
// control/status, with CPU writes taking priority over timer updates.
module timer_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        th_we,
  input  logic        tl_we,
  input  logic        tcon_we,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  logic overflow;

  assign overflow = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);

  // NOTE: sequential state uses non-blocking assignments so the reload below
  // samples the pre-edge TH even when the CPU rewrites TH in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th <= '0;
    end else if (th_we) begin
      th <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tl <= '0;
    end else if (tl_we) begin
      tl <= wdata;
    end else if (tcon[TCON_EN]) begin
      tl <= overflow ? th : tl + 32'd1;
    end
  end

  // A CPU write to TCON replaces all three bits, so a status set in the
  // same cycle is intentionally lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcon <= '0;
    end else if (tcon_we) begin
      tcon <= wdata[2:0];
    end else if (overflow && tcon[TCON_IE]) begin
      tcon[TCON_IS] <= 1'b1;
    end
  end

  assign irq = tcon[TCON_IE] & tcon[TCON_IS];

endmodule

// File: rtl/data_memory_mmio.sv
// MEM-stage data memory: word RAM plus memory-mapped timer, LEDs, 7-segment
// digits and systick, with a zero-latency combinational read path.
module data_memory_mmio
  import cpu_pkg::*;
#(
  parameter int RAM_WORDS = RAM_WORDS_DEFAULT,
  parameter int ADDR_W    = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_read_data,
  output logic        o_irq,
  output logic [7:0]  o_leds,
  output logic [11:0] o_digits,
  output logic [31:0] o_systick
);

  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  sel_e              sel;
  logic [ADDR_W-1:0] ram_idx;
  logic [31:0]       ram [RAM_WORDS];
  logic [31:0]       th;
  logic [31:0]       tl;
  logic [2:0]        tcon;

  assign sel     = decode(i_addr, RAM_BYTES);
  assign ram_idx = i_addr[ADDR_W+1:2];

  // NOTE: the RAM array has no reset; software must write before reading.
  always_ff @(posedge clk) begin
    if (i_mem_write && sel == SEL_RAM) begin
      ram[ram_idx] <= i_write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_leds   <= '0;
      o_digits <= '0;
    end else if (i_mem_write) begin
      if (sel == SEL_LEDS)   o_leds   <= i_write_data[7:0];
      if (sel == SEL_DIGITS) o_digits <= i_write_data[11:0];
    end
  end

  // Free-running; bus writes to its address are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_systick <= '0;
    end else begin
      o_systick <= o_systick + 32'd1;
    end
  end

  timer_unit u_timer (
    .clk     (clk),
    .reset   (reset),
    .th_we   (i_mem_write && sel == SEL_TH),
    .tl_we   (i_mem_write && sel == SEL_TL),
    .tcon_we (i_mem_write && sel == SEL_TCON),
    .wdata   (i_write_data),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (o_irq)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    o_read_data = '0;
    if (i_mem_read) begin
      case (sel)
        SEL_RAM:     o_read_data = ram[ram_idx];
        SEL_TH:      o_read_data = th;
        SEL_TL:      o_read_data = tl;
        SEL_TCON:    o_read_data = {29'd0, tcon};
        SEL_LEDS:    o_read_data = {24'd0, o_leds};
        SEL_DIGITS:  o_read_data = {20'd0, o_digits};
        SEL_SYSTICK: o_read_data = o_systick;
        default:     o_read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_mmio.sv
// Self-checking bench for data_memory_mmio: directed steps from the address
// map and timer rules, plus randomized RAM/LED/timer trials against a model.
module tb_data_memory_mmio;

  localparam logic [31:0] A_TH      = 32'h4000_0000;
  localparam logic [31:0] A_TL      = 32'h4000_0004;
  localparam logic [31:0] A_TCON    = 32'h4000_0008;
  localparam logic [31:0] A_LEDS    = 32'h4000_000C;
  localparam logic [31:0] A_DIGITS  = 32'h4000_0010;
  localparam logic [31:0] A_SYSTICK = 32'h4000_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] read_data;
  logic        irq;
  logic [7:0]  leds;
  logic [11:0] digits;
  logic [31:0] systick;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_m [0:511];
  bit          ram_v [0:511];

  data_memory_mmio #(.RAM_WORDS(512), .ADDR_W(9)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_mem_read   (mem_read),
    .i_mem_write  (mem_write),
    .i_addr       (addr),
    .i_write_data (wdata),
    .o_read_data  (read_data),
    .o_irq        (irq),
    .o_leds       (leds),
    .o_digits     (digits),
    .o_systick    (systick)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts and ends just after a rising edge; consumes exactly one edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_write = 1'b1;
    addr      = a;
    wdata     = d;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
  endtask

  // Combinational read; consumes no clock edge.
  task automatic bus_read_check(input logic [31:0] a, input logic [31:0] exp, input string tag);
    mem_read = 1'b1;
    addr     = a;
    #1;
    check(tag, read_data, exp);
    mem_read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected TL after n enabled edges starting from v, from the reload rules.
  function automatic logic [31:0] exp_tl(input logic [31:0] v, input logic [31:0] th, input int n);
    longint unsigned k, r, period;
    k = 64'hFFFF_FFFF - {32'd0, v};
    if (longint'(n) <= k) return v + 32'(n);
    r      = longint'(n) - k - 1;
    period = 64'h1_0000_0000 - {32'd0, th};
    return th + 32'(r % period);
  endfunction

  initial begin
    logic [31:0] s0, th_r, v, d;
    int          k, n, idx;
    int          pool [8];
    bit          is_set;

    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    #1;
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_leds", {24'd0, leds}, 32'd0);
    check("reset_digits", {20'd0, digits}, 32'd0);
    check("reset_systick", systick, 32'd0);
    check("reset_rdata", read_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    check("systick_first_edge", systick, 32'd1);

    // RAM basics
    bus_write(32'h10, 32'hDEAD_BEEF);
    bus_read_check(32'h10, 32'hDEAD_BEEF, "ram_read");
    bus_read_check(32'h13, 32'hDEAD_BEEF, "ram_read_unaligned");
    addr = 32'h10; mem_read = 1'b0; #1;
    check("ram_no_read_strobe", read_data, 32'd0);

    // Read and write together: old data before the edge, new after
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b1; addr = 32'h10; wdata = 32'h1111_1111;
    #1;
    check("rw_same_old", read_data, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    #1;
    check("rw_same_new", read_data, 32'h1111_1111);
    mem_read = 1'b0;

    // RAM boundaries: last word, first byte beyond RAM does not alias word 0
    bus_write(32'h0, 32'hA0A0_0001);
    bus_write(32'h7FC, 32'h5555_AAAA);
    bus_write(32'h800, 32'h9999_9999);
    bus_read_check(32'h7FC, 32'h5555_AAAA, "ram_last_word");
    bus_read_check(32'h0, 32'hA0A0_0001, "ram_no_alias");
    bus_read_check(32'h800, 32'd0, "past_ram_reads_zero");

    // Peripheral registers
    bus_write(A_LEDS, 32'h1A5);
    check("leds_port", {24'd0, leds}, 32'hA5);
    bus_read_check(A_LEDS, 32'hA5, "leds_read");
    bus_write(A_DIGITS, 32'hFFFF);
    check("digits_port", {20'd0, digits}, 32'hFFF);
    bus_read_check(A_DIGITS, 32'hFFF, "digits_read");
    s0 = systick;
    bus_write(A_SYSTICK, 32'h0);
    check("systick_write_ignored", systick, s0 + 32'd1);
    s0 = systick;
    idle(5);
    check("systick_count", systick, s0 + 32'd5);

    // Unmapped space
    bus_write(32'h4000_0020, 32'h1234_5678);
    bus_read_check(32'h4000_0020, 32'd0, "unmapped_periph");
    bus_read_check(32'h8000_0000, 32'd0, "unmapped_high");

    // Timer reload and interrupt
    bus_write(A_TH, 32'hFFFF_FFFD);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'd3);
    idle(1);
    bus_read_check(A_TL, 32'hFFFF_FFFF, "timer_cycle1");
    idle(1);
    bus_read_check(A_TL, 32'hFFFF_FFFD, "timer_reload");
    bus_read_check(A_TCON, 32'd7, "timer_status");
    check("timer_irq", {31'd0, irq}, 32'd1);
    bus_write(A_TCON, 32'd3);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    bus_read_check(A_TCON, 32'd3, "tcon_cleared");

    // Disabled timer holds TL
    bus_write(A_TCON, 32'd0);
    bus_write(A_TL, 32'h55);
    idle(3);
    bus_read_check(A_TL, 32'h55, "timer_hold");

    // CPU write to TL wins over an overflow reload
    bus_write(A_TH, 32'h10);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'd1);
    bus_write(A_TL, 32'h5);
    bus_read_check(A_TL, 32'h5, "collide_tl");
    idle(1);
    bus_read_check(A_TL, 32'h6, "collide_tl_next");

    // CPU write to TCON wins over a status set
    bus_write(A_TCON, 32'd0);
    bus_write(A_TH, 32'h0);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'd3);
    bus_write(A_TCON, 32'd1);
    bus_read_check(A_TCON, 32'd1, "collide_tcon");
    check("collide_tcon_irq", {31'd0, irq}, 32'd0);
    bus_read_check(A_TL, 32'd0, "collide_tcon_reload");

    // TH written in an overflow cycle: reload uses the old TH
    bus_write(A_TCON, 32'd0);
    bus_write(A_TH, 32'h100);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'd1);
    bus_write(A_TH, 32'h200);
    bus_read_check(A_TL, 32'h100, "collide_th_old");
    bus_read_check(A_TH, 32'h200, "collide_th_new");

    // Randomized timer trials near overflow
    for (int t = 0; t < 6; t++) begin
      th_r = $urandom;
      if (t == 0) th_r = 32'hFFFF_FFFF;
      k = $urandom_range(0, 4);
      n = $urandom_range(0, 8);
      v = 32'hFFFF_FFFF - 32'(k);
      bus_write(A_TCON, 32'd0);
      bus_write(A_TH, th_r);
      bus_write(A_TL, v);
      bus_write(A_TCON, 32'd3);
      if (n > 0) idle(n);
      is_set = (n > k);
      bus_read_check(A_TL, exp_tl(v, th_r, n), $sformatf("rand_tl_%0d", t));
      bus_read_check(A_TCON, {29'd0, is_set, 2'b11}, $sformatf("rand_tcon_%0d", t));
      check($sformatf("rand_irq_%0d", t), {31'd0, irq}, {31'd0, is_set});
    end
    bus_write(A_TCON, 32'd0);

    // Randomized RAM traffic over a small pool of word addresses
    foreach (pool[i]) pool[i] = $urandom_range(0, 511);
    for (int t = 0; t < 40; t++) begin
      idx = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 1 || !ram_v[idx]) begin
        d = $urandom;
        bus_write({20'd0, idx[9:0], 2'b00}, d);
        ram_m[idx] = d;
        ram_v[idx] = 1'b1;
      end else begin
        bus_read_check({20'd0, idx[9:0], 2'($urandom_range(0, 3))}, ram_m[idx],
                       $sformatf("rand_ram_%0d", idx));
        idle(1);
      end
    end

    // Randomized LED / digit writes (upper bits dropped)
    for (int t = 0; t < 4; t++) begin
      d = $urandom;
      bus_write(A_LEDS, d);
      bus_read_check(A_LEDS, {24'd0, d[7:0]}, "rand_leds");
      d = $urandom;
      bus_write(A_DIGITS, d);
      check("rand_digits", {20'd0, digits}, {20'd0, d[11:0]});
    end

    // Reset in the middle of counting
    bus_write(A_TL, 32'h100);
    bus_write(A_TCON, 32'd7);
    idle(2);
    bus_read_check(A_TL, 32'h102, "pre_reset_tl");
    check("pre_reset_irq", {31'd0, irq}, 32'd1);
    reset = 1'b1;
    #1;
    bus_read_check(A_TL, 32'd0, "midreset_tl");
    bus_read_check(A_TCON, 32'd0, "midreset_tcon");
    check("midreset_irq", {31'd0, irq}, 32'd0);
    check("midreset_systick", systick, 32'd0);
    check("midreset_leds", {24'd0, leds}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    check("post_reset_systick", systick, 32'd1);
    bus_read_check(A_TL, 32'd0, "post_reset_tl_held");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
